systolic_ctrl: RTL
==================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width.
REQ-002 SHALL have parameter ROWS, default 4, array rows.
REQ-003 SHALL have parameter COLS, default 4, array columns.
REQ-004 SHALL have parameter KW, default 8, width of inner-dimension length K.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, job request, sampled in IDLE only.
REQ-008 SHALL have port k_len, input, KW, inner dimension K, sampled with start.
REQ-009 SHALL have port busy, output, 1, high in FEED and DRAIN.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port mem_rd_en, output, 1, operand read strobe.
REQ-012 SHALL have port mem_rd_addr, output, KW, operand index k.
REQ-013 SHALL have port a_rd_data, input, ROWS*DATA_W, A column k, row i at [i*DATA_W +: DATA_W], valid 1 cycle after mem_rd_en.
REQ-014 SHALL have port b_rd_data, input, COLS*DATA_W, B row k, column j at [j*DATA_W +: DATA_W], same timing.
REQ-015 SHALL have port arr_valid, output, 1, wavefront valid to the array origin.
REQ-016 SHALL have port a_in_bus, output, ROWS*DATA_W, skewed left-edge operands.
REQ-017 SHALL have port b_in_bus, output, COLS*DATA_W, skewed top-edge operands.

Function
REQ-018 SHALL implement FSM states IDLE, FEED, DRAIN, DONE.
REQ-019 SHALL go IDLE->FEED on start=1 with k_len>0, latching k_len; cycle of acceptance is cycle 0.
REQ-020 SHALL go IDLE->DONE on start=1 with k_len=0, with no reads and no arr_valid.
REQ-021 SHALL ignore start outside IDLE, including start during DONE.
REQ-022 SHALL in FEED assert mem_rd_en with mem_rd_addr=0..K-1 on cycles 1..K, one index per cycle.
REQ-023 SHALL go FEED->DRAIN after issuing index K-1.
REQ-024 SHALL delay row i of A by i cycles and column j of B by j cycles relative to returned read data (row 0/col 0 undelayed).
REQ-025 SHALL drive zero on every skewed lane whose source read was not issued, no stale data.
REQ-026 SHALL assert arr_valid on cycles 2..K+1, aligned to row-0/col-0 data.
REQ-027 SHALL stay in DRAIN for exactly ROWS+COLS cycles, counted by a drain counter, then go to DONE.
REQ-028 SHALL in DONE assert done for one cycle, then return to IDLE.
REQ-029 SHALL have skew registers flushed to zero by the end of DRAIN, for any K.
REQ-030 SHALL, on rst assertion mid-job, abandon the job immediately without producing done.

Reset
REQ-031 SHALL on rst set state IDLE, busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, arr_valid=0, and all skew registers and bus outputs to 0.
REQ-032 SHALL accept a new start on the first cycle after rst deasserts.

Structure
REQ-033 SHALL place the FSM state enum and the drain-length constant (ROWS+COLS) in shared package systolic_pkg.
REQ-034 SHALL implement per-lane delay as sub-module skew_buffer (parameters LANES, DATA_W; lane n delayed n cycles, zero-filled when input invalid), instantiated once for A and once for B.

Verification
REQ-035 SHALL cover: ROWS=COLS=4, K=3, A col k = {1,2,3,4}*(k+1) -> reads on cycles 1..3; arr_valid on cycles 2..4; row 3 lane nonzero on cycles 5..7 only; done on cycle 12.
REQ-036 SHALL cover: start with k_len=0 -> done on cycle 1, mem_rd_en and arr_valid never high, busy never high.
REQ-037 SHALL cover: start held high continuously -> jobs back-to-back with one IDLE cycle between done and the next acceptance, no overlap.
REQ-038 SHALL cover: rst asserted during FEED at K=8 cycle 4 -> all outputs 0 in that cycle, no done, clean job after release.
REQ-039 SHALL cover: K=255 -> mem_rd_addr reaches 254 with no wrap, arr_valid exactly 255 cycles, done on cycle 264.
REQ-040 SHALL cover: start pulsed while busy -> ignored, exactly one done per accepted job.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feed controller: FSM encoding
// and the drain-length rule used by the controller.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // The last operand must travel the full skew plus the array diagonal.
  function automatic int drain_cycles(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew.sv
// Per-lane delay line: lane n is delayed n cycles, lanes carry zero whenever
// the source word was not a valid read.
module skew_buffer #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  input  logic [LANES*DATA_W-1:0] i_data,
  output logic [LANES*DATA_W-1:0] o_data
);

  logic [LANES*DATA_W-1:0] w_in;

  assign w_in = i_vld ? i_data : '0;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    if (n == 0) begin : g_pass
      assign o_data[0 +: DATA_W] = w_in[0 +: DATA_W];
    end else begin : g_dly
      logic [DATA_W-1:0] r_dly [n];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < n; s++) r_dly[s] <= '0;
        end else begin
          r_dly[0] <= w_in[n*DATA_W +: DATA_W];
          for (int s = 1; s < n; s++) r_dly[s] <= r_dly[s-1];
        end
      end

      assign o_data[n*DATA_W +: DATA_W] = r_dly[n-1];
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Operand feed controller for a ROWS x COLS systolic array: reads K operand
// columns/rows, skews them onto the array edges, drains, and pulses done.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int KW     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [KW-1:0]          mem_rd_addr,
  input  logic [ROWS*DATA_W-1:0] a_rd_data,
  input  logic [COLS*DATA_W-1:0] b_rd_data,
  output logic                   arr_valid,
  output logic [ROWS*DATA_W-1:0] a_in_bus,
  output logic [COLS*DATA_W-1:0] b_in_bus
);

  localparam int DRAIN_LEN = drain_cycles(ROWS, COLS);
  localparam int DCW       = $clog2(DRAIN_LEN + 1);

  state_t          r_state;
  logic [KW-1:0]   r_klen;
  logic [KW-1:0]   r_addr;
  logic [DCW-1:0]  r_drain;
  logic            r_rd_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_klen   <= '0;
      r_addr   <= '0;
      r_drain  <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      // Read data returns one cycle after the strobe; its valid tracks it.
      r_rd_vld <= (r_state == ST_FEED);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_klen  <= k_len;
            r_addr  <= '0;
            r_drain <= '0;
            r_state <= (k_len == '0) ? ST_DONE : ST_FEED;
          end
        end
        ST_FEED: begin
          if (r_addr == r_klen - KW'(1)) begin
            r_addr  <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_addr <= r_addr + KW'(1);
          end
        end
        ST_DRAIN: begin
          if (r_drain == DCW'(DRAIN_LEN - 1)) begin
            r_drain <= '0;
            r_state <= ST_DONE;
          end else begin
            r_drain <= r_drain + DCW'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == ST_FEED) || (r_state == ST_DRAIN);
  assign done        = (r_state == ST_DONE);
  assign mem_rd_en   = (r_state == ST_FEED);
  assign mem_rd_addr = r_addr;
  assign arr_valid   = r_rd_vld;

  skew_buffer #(.LANES(ROWS), .DATA_W(DATA_W)) u_skew_a (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (r_rd_vld),
    .i_data (a_rd_data),
    .o_data (a_in_bus)
  );

  skew_buffer #(.LANES(COLS), .DATA_W(DATA_W)) u_skew_b (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (r_rd_vld),
    .i_data (b_rd_data),
    .o_data (b_in_bus)
  );

endmodule
